sc_stream_to_binary: RTL and testbench

SC_STREAM_TO_BINARY -- requirements
Module: sc_stream_to_binary

---
 rtl/sc_stream_to_binary.sv | 132 +++++++++++++
 tb/tb_sc_stream_to_binary.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/sc_stream_to_binary.sv
// sc_stream_to_binary: converts NUM_STREAMS parallel stochastic bitstreams
// into binary values by counting '1' bits over a window of STREAM_LENGTH
// valid samples, then holds the results until the consumer accepts them.
//
// Optional feature: define SC_BIPOLAR_EN to emit bipolar results
// (2*count - STREAM_LENGTH, two's complement) instead of the plain count.
// Port widths and timing are the same in both builds.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; counters hold their last values
// COUNT | accumulating valid samples until STREAM_LENGTH have been seen
// DONE  | results valid and frozen until outReady
module sc_stream_to_binary #(
  parameter  int NUM_STREAMS   = 16,
  parameter  int STREAM_LENGTH = 256,
  localparam int COUNT_WIDTH   = $clog2(STREAM_LENGTH + 1),
  localparam int OUT_WIDTH     = COUNT_WIDTH + 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [NUM_STREAMS-1:0]         inputStreams,
  input  logic                           inValid,
  output logic                           busy,
  output logic [NUM_STREAMS*OUT_WIDTH-1:0] results,
  output logic                           outValid,
  input  logic                           outReady
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] LAST_SAMPLE = COUNT_WIDTH'(STREAM_LENGTH - 1);

  state_t                         state_q, state_d;
  logic [COUNT_WIDTH-1:0]         cnt_q [NUM_STREAMS];
  logic [COUNT_WIDTH-1:0]         cnt_d [NUM_STREAMS];
  logic [COUNT_WIDTH-1:0]         samp_q, samp_d;
  logic [NUM_STREAMS*OUT_WIDTH-1:0] res_q, res_d;
  logic                           clear, accum, load;

  // Result encoding applied to a finished count.
  function automatic logic [OUT_WIDTH-1:0] encode(input logic [COUNT_WIDTH-1:0] c);
`ifdef SC_BIPOLAR_EN
    // 2*c never overflows OUT_WIDTH because STREAM_LENGTH < 2**COUNT_WIDTH.
    return {c, 1'b0} - OUT_WIDTH'(STREAM_LENGTH);
`else
    return {1'b0, c};
`endif
  endfunction

  // Next-state logic and datapath control strobes.
  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    accum   = 1'b0;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          clear   = 1'b1;
          state_d = COUNT;
        end
      end
      COUNT: begin
        if (inValid) begin
          accum = 1'b1;
          if (samp_q == LAST_SAMPLE) begin
            load    = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (outReady) begin
          if (start) begin
            clear   = 1'b1;
            state_d = COUNT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Counter update and result capture on the final sample.
  always_comb begin
    samp_d = samp_q;
    for (int k = 0; k < NUM_STREAMS; k++) cnt_d[k] = cnt_q[k];
    if (clear) begin
      samp_d = '0;
      for (int k = 0; k < NUM_STREAMS; k++) cnt_d[k] = '0;
    end else if (accum) begin
      samp_d = samp_q + 1'b1;
      for (int k = 0; k < NUM_STREAMS; k++)
        cnt_d[k] = cnt_q[k] + {{(COUNT_WIDTH-1){1'b0}}, inputStreams[k]};
    end
    // Results are registered from the post-update counts so they are frozen
    // for the whole DONE period and read as zero straight after reset.
    res_d = res_q;
    if (load) begin
      for (int k = 0; k < NUM_STREAMS; k++)
        res_d[k*OUT_WIDTH +: OUT_WIDTH] = encode(cnt_d[k]);
    end
  end

  // State, counters and result register; synchronous reset wins over all inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      samp_q  <= '0;
      res_q   <= '0;
      for (int k = 0; k < NUM_STREAMS; k++) cnt_q[k] <= '0;
    end else begin
      state_q <= state_d;
      samp_q  <= samp_d;
      res_q   <= res_d;
      for (int k = 0; k < NUM_STREAMS; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  assign busy     = (state_q == COUNT);
  assign outValid = (state_q == DONE);
  assign results  = res_q;

endmodule

// File: tb/tb_sc_stream_to_binary.sv
// Bench for sc_stream_to_binary with NUM_STREAMS=4, STREAM_LENGTH=8.
// Expected results come from per-window ones-counts kept by the bench.
module tb_sc_stream_to_binary;

  localparam int NS = 4;
  localparam int SL = 8;
  localparam int OW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [NS-1:0] inputStreams = '0;
  logic          inValid = 1'b0;
  logic          busy;
  logic [NS*OW-1:0] results;
  logic          outValid;
  logic          outReady = 1'b0;

  int n_chk = 0;
  int n_err = 0;
  int m_cnt [NS];
  logic [NS*OW-1:0] exp_res;

  sc_stream_to_binary #(.NUM_STREAMS(NS), .STREAM_LENGTH(SL)) dut (
    .clk(clk), .rst(rst), .start(start), .inputStreams(inputStreams),
    .inValid(inValid), .busy(busy), .results(results),
    .outValid(outValid), .outReady(outReady)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NS*OW-1:0] model_results();
    logic [NS*OW-1:0] r;
    int v;
    r = '0;
    for (int k = 0; k < NS; k++) begin
`ifdef SC_BIPOLAR_EN
      v = 2 * m_cnt[k] - SL;
`else
      v = m_cnt[k];
`endif
      r[k*OW +: OW] = OW'(v);
    end
    return r;
  endfunction

  // Start-cycle stream bits are driven high to show they are not counted.
  task automatic start_window(input string tag);
    start = 1'b1; inValid = 1'b1; inputStreams = '1;
    tick();
    start = 1'b0; inValid = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
  endtask

  // mode 0: stream0 only, continuous; 1: alternating valid, stream2 1010;
  // 2: random valid and random stream bits.
  task automatic count_window(input string tag, input int mode);
    int n, cyc, early;
    logic v;
    logic [NS-1:0] s;
    n = 0; cyc = 0; early = 0;
    for (int k = 0; k < NS; k++) m_cnt[k] = 0;
    while (n < SL && cyc < 200) begin
      case (mode)
        0: begin v = 1'b1; s = 4'b0001; end
        1: begin
          v = (cyc % 2 == 0);
          s = v ? ((n % 2 == 0) ? 4'b0100 : 4'b0000) : 4'b1111;
        end
        default: begin v = ($urandom_range(0, 3) != 0); s = NS'($urandom); end
      endcase
      inValid = v; inputStreams = s;
      if (v) begin
        for (int k = 0; k < NS; k++) m_cnt[k] += int'(s[k]);
        n++;
      end
      tick();
      cyc++;
      if (n < SL && (outValid || !busy)) early++;
    end
    inValid = 1'b0; inputStreams = NS'($urandom);
    exp_res = model_results();
    chk({tag, "_no_early"}, 32'(early), 32'd0);
    chk({tag, "_outValid"}, 32'(outValid), 32'd1);
    chk({tag, "_busy_done"}, 32'(busy), 32'd0);
    chk({tag, "_results"}, 32'(results), 32'(exp_res));
  endtask

  // Hold in DONE with outReady=0 while optionally pulsing start.
  task automatic hold_done(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      outReady = 1'b0; start = $urandom_range(0, 1) != 0;
      inValid = 1'b1; inputStreams = NS'($urandom);
      tick();
      chk({tag, "_hold_valid"}, 32'(outValid), 32'd1);
      chk({tag, "_hold_res"}, 32'(results), 32'(exp_res));
      chk({tag, "_hold_busy"}, 32'(busy), 32'd0);
    end
    start = 1'b0; inValid = 1'b0;
  endtask

  task automatic release_done(input string tag);
    outReady = 1'b1; start = 1'b0;
    tick();
    outReady = 1'b0;
    chk({tag, "_rel_valid"}, 32'(outValid), 32'd0);
    chk({tag, "_rel_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic back_to_back(input string tag);
    outReady = 1'b1; start = 1'b1; inValid = 1'b1; inputStreams = '1;
    tick();
    outReady = 1'b0; start = 1'b0; inValid = 1'b0;
    chk({tag, "_b2b_busy"}, 32'(busy), 32'd1);
    chk({tag, "_b2b_valid"}, 32'(outValid), 32'd0);
  endtask

  initial begin
    // reset with other controls active: reset must win
    start = 1'b1; outReady = 1'b1; inValid = 1'b1; inputStreams = '1;
    tick(); tick();
    rst = 1'b0; start = 1'b0; outReady = 1'b0; inValid = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(outValid), 32'd0);
    chk("rst_results", 32'(results), 32'd0);

    // outReady outside DONE is ignored
    outReady = 1'b1; tick(); outReady = 1'b0;
    chk("idle_ready_ignored", 32'(outValid | busy), 32'd0);

    // single stream, full window
    start_window("s0");
    count_window("s0", 0);
    release_done("s0");

    // alternating valid with noise on invalid cycles
    start_window("alt");
    count_window("alt", 1);
    chk("alt_stream2", 32'(results[2*OW +: OW]), 32'(exp_res[2*OW +: OW]));

    // DONE hold with start pulses, then release
    hold_done("hold", 5);
    release_done("hold");
    chk("hold_no_new_window", 32'(busy), 32'd0);

    // back-to-back window
    start_window("bb0");
    count_window("bb0", 2);
    back_to_back("bb");
    count_window("bb1", 0);
    release_done("bb1");

    // random windows with random hold and exit
    for (int w = 0; w < 6; w++) begin
      start_window("rnd");
      count_window("rnd", 2);
      hold_done("rnd", $urandom_range(0, 3));
      if ($urandom_range(0, 1) != 0) begin
        back_to_back("rnd");
        count_window("rnd_b", 2);
      end
      release_done("rnd");
    end

    // mid-window reset
    start_window("mid");
    for (int i = 0; i < 4; i++) begin
      inValid = 1'b1; inputStreams = '1; tick();
    end
    rst = 1'b1; start = 1'b1; outReady = 1'b1; inValid = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0; outReady = 1'b0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_valid", 32'(outValid), 32'd0);
    chk("mid_rst_results", 32'(results), 32'd0);
    for (int i = 0; i < 10; i++) begin
      inValid = 1'b1; inputStreams = '1; tick();
    end
    inValid = 1'b0;
    chk("post_rst_idle_busy", 32'(busy), 32'd0);
    chk("post_rst_idle_valid", 32'(outValid), 32'd0);
    start_window("after_rst");
    count_window("after_rst", 0);
    release_done("after_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
